// File: rtl/race_pkg.sv
// race_pkg: shared constants and geometry helpers for the race drawing sequencer.
//   - FSM state encodings (3-bit, legacy-compatible localparams)
//   - VGA colour constants
//   - car_x(): x origin of the car sprite for a given lane
package race_pkg;

  // Sequencer states
  localparam logic [2:0] ST_DRAW_BG    = 3'd0;
  localparam logic [2:0] ST_DRAW_CAR   = 3'd1;
  localparam logic [2:0] ST_WAIT_START = 3'd2;
  localparam logic [2:0] ST_WAIT_MOVE  = 3'd3;
  localparam logic [2:0] ST_ERASE      = 3'd4;

  // Pixel colours (R,G,B bit order)
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] RED   = 3'b100;

  // Car is centred inside its lane; usable both at elaboration and on a live lane value
  function automatic int unsigned car_x(input int unsigned grass_w,
                                        input int unsigned lane_w,
                                        input int unsigned car_w,
                                        input int unsigned l);
    return grass_w + l * lane_w + (lane_w - car_w) / 2;
  endfunction

endpackage

// File: rtl/rect_sweep.sv
// rect_sweep: raster walker over one axis-aligned rectangle, x inner, y outer.
// Ports:
//   clock, reset   - clock, synchronous active-high reset (sweep returns to the
//                    full-screen rectangle at (0,0))
//   i_load         - capture a new rectangle; position jumps to its origin
//   i_en           - advance one pixel (ignored while i_load is high)
//   i_x0, i_y0     - rectangle origin
//   i_xspan        - width  - 1
//   i_yspan        - height - 1
//   o_x, o_y       - pixel currently held
//   o_last_c       - combinational: the held pixel is the rectangle's last one
module rect_sweep #(
  parameter int unsigned X_W   = 8,
  parameter int unsigned Y_W   = 7,
  parameter int unsigned RST_W = 160,
  parameter int unsigned RST_H = 120
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           i_load,
  input  logic           i_en,
  input  logic [X_W-1:0] i_x0,
  input  logic [Y_W-1:0] i_y0,
  input  logic [X_W-1:0] i_xspan,
  input  logic [Y_W-1:0] i_yspan,
  output logic [X_W-1:0] o_x,
  output logic [Y_W-1:0] o_y,
  output logic           o_last_c
);

  logic [X_W-1:0] r_x;
  logic [X_W-1:0] r_x0;
  logic [X_W-1:0] r_x_end;
  logic [Y_W-1:0] r_y;
  logic [Y_W-1:0] r_y_end;

  // Position and bounds; end coordinates are stored so the step test is a compare
  always_ff @(posedge clock) begin
    if (reset) begin
      r_x     <= '0;
      r_y     <= '0;
      r_x0    <= '0;
      r_x_end <= X_W'(RST_W - 1);
      r_y_end <= Y_W'(RST_H - 1);
    end else if (i_load) begin
      r_x     <= i_x0;
      r_y     <= i_y0;
      r_x0    <= i_x0;
      r_x_end <= i_x0 + i_xspan;
      r_y_end <= i_y0 + i_yspan;
    end else if (i_en) begin
      if (r_x == r_x_end) begin
        r_x <= r_x0;
        r_y <= r_y + Y_W'(1);
      end else begin
        r_x <= r_x + X_W'(1);
      end
    end
  end

  assign o_x      = r_x;
  assign o_y      = r_y;
  assign o_last_c = (r_x == r_x_end) && (r_y == r_y_end);

endmodule

// File: rtl/race_draw_seq.sv
// race_draw_seq: drawing sequencer for the racing game's VGA frame buffer.
// Paints the grass/road/grass background, draws the player car, and performs
// lane changes as erase-old / update-lane / draw-new, one pixel per cycle.
// Ports:
//   clock, reset            - clock, synchronous active-high reset
//   start                   - level; leaves WAIT_START
//   move_left, move_right   - level; sampled only in WAIT_MOVE
//   redraw                  - pulse; full repaint, honoured only while idle
//   plot, x, y, colour      - registered pixel write to the VGA adapter
//   lane                    - current car lane
//   busy                    - a rectangle is being written (aligned with plot)
//   frame_done              - pulse with the last pixel of the first car after a repaint
module race_draw_seq
  import race_pkg::*;
#(
  parameter int unsigned SCREEN_W   = 160,
  parameter int unsigned SCREEN_H   = 120,
  parameter int unsigned X_W        = 8,
  parameter int unsigned Y_W        = 7,
  parameter int unsigned GRASS_W    = 30,
  parameter int unsigned NUM_LANES  = 3,
  parameter int unsigned CAR_W      = 5,
  parameter int unsigned CAR_H      = 12,
  parameter int unsigned CAR_Y_GAP  = 4,
  parameter int unsigned START_LANE = 1,
  parameter int unsigned COLOUR_W   = 3,
  localparam int unsigned LANE_BITS = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 move_left,
  input  logic                 move_right,
  input  logic                 redraw,
  output logic                 plot,
  output logic [X_W-1:0]       x,
  output logic [Y_W-1:0]       y,
  output logic [COLOUR_W-1:0]  colour,
  output logic [LANE_BITS-1:0] lane,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int unsigned ROAD_W    = SCREEN_W - 2 * GRASS_W;
  localparam int unsigned LANE_W    = ROAD_W / NUM_LANES;
  localparam int unsigned CAR_Y     = SCREEN_H - CAR_H - CAR_Y_GAP;
  localparam int unsigned GRASS_R   = SCREEN_W - GRASS_W;
  localparam int unsigned LAST_LANE = NUM_LANES - 1;

  localparam logic [X_W-1:0] GRASS_L_X  = X_W'(GRASS_W);
  localparam logic [X_W-1:0] GRASS_R_X  = X_W'(GRASS_R);
  localparam logic [Y_W-1:0] CAR_Y0     = Y_W'(CAR_Y);
  localparam logic [X_W-1:0] CAR_XSPAN  = X_W'(CAR_W - 1);
  localparam logic [Y_W-1:0] CAR_YSPAN  = Y_W'(CAR_H - 1);
  localparam logic [X_W-1:0] BG_XSPAN   = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] BG_YSPAN   = Y_W'(SCREEN_H - 1);
  localparam logic [LANE_BITS-1:0] LANE_MAX  = LANE_BITS'(LAST_LANE);
  localparam logic [LANE_BITS-1:0] LANE_INIT = LANE_BITS'(START_LANE);

  // Geometry sanity, resolved at elaboration
  localparam bit GEOM_OK =
      (NUM_LANES >= 1) && (START_LANE < NUM_LANES) && (CAR_W <= LANE_W) &&
      (2 * GRASS_W < SCREEN_W) && (CAR_H + CAR_Y_GAP <= SCREEN_H) &&
      (car_x(GRASS_W, LANE_W, CAR_W, LAST_LANE) + CAR_W <= GRASS_R) &&
      (SCREEN_W <= (1 << X_W)) && (SCREEN_H <= (1 << Y_W)) && (COLOUR_W >= 3);

  if (!GEOM_OK) begin : g_bad_geometry
    $error("race_draw_seq: geometry does not fit the screen or coordinate widths");
  end

  logic [2:0]           r_state;
  logic [2:0]           w_state_nxt;
  logic [LANE_BITS-1:0] r_lane;
  logic [LANE_BITS-1:0] w_lane_nxt;
  logic [LANE_BITS-1:0] r_target;
  logic [LANE_BITS-1:0] w_target_nxt;
  logic                 r_first;
  logic                 w_first_nxt;

  logic                 w_load;
  logic                 w_en;
  logic                 w_bg_req;
  logic [X_W-1:0]       w_ld_x0;
  logic [Y_W-1:0]       w_ld_y0;
  logic [X_W-1:0]       w_ld_xspan;
  logic [Y_W-1:0]       w_ld_yspan;
  logic [X_W-1:0]       w_sx;
  logic [Y_W-1:0]       w_sy;
  logic                 w_last;
  logic [X_W-1:0]       w_car_x_cur;
  logic [X_W-1:0]       w_car_x_tgt;
  logic [COLOUR_W-1:0]  w_colour;
  logic                 w_busy_st;
  logic                 w_frame_done;

  logic                 r_plot;
  logic [X_W-1:0]       r_x;
  logic [Y_W-1:0]       r_y;
  logic [COLOUR_W-1:0]  r_colour;
  logic                 r_busy;
  logic                 r_frame_done;

  assign w_car_x_cur = X_W'(car_x(GRASS_W, LANE_W, CAR_W, 32'(r_lane)));
  assign w_car_x_tgt = X_W'(car_x(GRASS_W, LANE_W, CAR_W, 32'(r_target)));

  rect_sweep #(
    .X_W   (X_W),
    .Y_W   (Y_W),
    .RST_W (SCREEN_W),
    .RST_H (SCREEN_H)
  ) u_sweep (
    .clock    (clock),
    .reset    (reset),
    .i_load   (w_load),
    .i_en     (w_en),
    .i_x0     (w_ld_x0),
    .i_y0     (w_ld_y0),
    .i_xspan  (w_ld_xspan),
    .i_yspan  (w_ld_yspan),
    .o_x      (w_sx),
    .o_y      (w_sy),
    .o_last_c (w_last)
  );

  // Next state, sweeper reload and pixel colour. The sweeper is reloaded on the
  // cycle that leaves a state so the next rectangle starts with no gap.
  always_comb begin
    w_state_nxt  = r_state;
    w_lane_nxt   = r_lane;
    w_target_nxt = r_target;
    w_first_nxt  = r_first;
    w_load       = 1'b0;
    w_en         = 1'b0;
    w_bg_req     = 1'b0;
    w_ld_x0      = w_car_x_cur;
    w_ld_y0      = CAR_Y0;
    w_ld_xspan   = CAR_XSPAN;
    w_ld_yspan   = CAR_YSPAN;
    w_colour     = COLOUR_W'(BLACK);

    case (r_state)
      ST_DRAW_BG: begin
        w_en = 1'b1;
        if ((w_sx < GRASS_L_X) || (w_sx >= GRASS_R_X)) w_colour = COLOUR_W'(GREEN);
        if (w_last) begin
          w_state_nxt = ST_DRAW_CAR;
          w_load      = 1'b1;
        end
      end
      ST_DRAW_CAR: begin
        w_en     = 1'b1;
        w_colour = COLOUR_W'(RED);
        if (w_last) begin
          if (r_first) begin
            w_state_nxt = ST_WAIT_START;
            w_first_nxt = 1'b0;
          end else begin
            w_state_nxt = ST_WAIT_MOVE;
          end
        end
      end
      ST_WAIT_START: begin
        if (redraw)     w_bg_req    = 1'b1;
        else if (start) w_state_nxt = ST_WAIT_MOVE;
      end
      ST_WAIT_MOVE: begin
        // Redraw beats a move; conflicting or edge-blocked moves are dropped
        if (redraw) begin
          w_bg_req = 1'b1;
        end else if (move_left && !move_right && (r_lane != '0)) begin
          w_target_nxt = r_lane - LANE_BITS'(1);
          w_state_nxt  = ST_ERASE;
          w_load       = 1'b1;
        end else if (move_right && !move_left && (r_lane != LANE_MAX)) begin
          w_target_nxt = r_lane + LANE_BITS'(1);
          w_state_nxt  = ST_ERASE;
          w_load       = 1'b1;
        end
      end
      ST_ERASE: begin
        w_en = 1'b1;
        if (w_last) begin
          w_lane_nxt  = r_target;
          w_state_nxt = ST_DRAW_CAR;
          w_load      = 1'b1;
          w_ld_x0     = w_car_x_tgt;
        end
      end
      default: w_bg_req = 1'b1;
    endcase

    // Full-screen repaint from the top-left corner
    if (w_bg_req) begin
      w_state_nxt = ST_DRAW_BG;
      w_first_nxt = 1'b1;
      w_load      = 1'b1;
      w_ld_x0     = '0;
      w_ld_y0     = '0;
      w_ld_xspan  = BG_XSPAN;
      w_ld_yspan  = BG_YSPAN;
    end
  end

  assign w_busy_st    = (r_state == ST_DRAW_BG) || (r_state == ST_DRAW_CAR) ||
                        (r_state == ST_ERASE);
  assign w_frame_done = (r_state == ST_DRAW_CAR) && w_last && r_first;

  // State and registered pixel outputs; outputs lag the sweeper by one cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_DRAW_BG;
      r_lane       <= LANE_INIT;
      r_target     <= LANE_INIT;
      r_first      <= 1'b1;
      r_plot       <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_colour     <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_lane       <= w_lane_nxt;
      r_target     <= w_target_nxt;
      r_first      <= w_first_nxt;
      r_plot       <= w_busy_st;
      r_x          <= w_sx;
      r_y          <= w_sy;
      r_colour     <= w_colour;
      r_busy       <= w_busy_st;
      r_frame_done <= w_frame_done;
    end
  end

  assign plot       = r_plot;
  assign x          = r_x;
  assign y          = r_y;
  assign colour     = r_colour;
  assign lane       = r_lane;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_race_draw_seq.sv
// tb_race_draw_seq: directed self-checking bench for race_draw_seq (default geometry).
module tb_race_draw_seq;

  localparam logic [2:0] C_GREEN = 3'b010;
  localparam logic [2:0] C_BLACK = 3'b000;
  localparam logic [2:0] C_RED   = 3'b100;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       move_left = 1'b0;
  logic       move_right = 1'b0;
  logic       redraw = 1'b0;
  logic       plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic [1:0] lane;
  logic       busy;
  logic       frame_done;

  int n_total = 0;
  int n_pass  = 0;
  int n_plot, n_green, n_black, n_red, n_fd;
  int red_xmin, red_xmax, red_ymin, red_ymax, blk_xmin, blk_xmax;
  int first_x, first_y;
  logic [2:0] row_col [0:159];

  always #5 clock = ~clock;

  race_draw_seq dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .move_left  (move_left),
    .move_right (move_right),
    .redraw     (redraw),
    .plot       (plot),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .lane       (lane),
    .busy       (busy),
    .frame_done (frame_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic clr_stats();
    n_plot = 0; n_green = 0; n_black = 0; n_red = 0; n_fd = 0;
    red_xmin = 9999; red_xmax = -1; red_ymin = 9999; red_ymax = -1;
    blk_xmin = 9999; blk_xmax = -1;
    first_x = -1; first_y = -1;
    for (int i = 0; i < 160; i++) row_col[i] = 3'bxxx;
  endtask

  // One clock; outputs sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clock);
    #1;
    if (plot === 1'b1) begin
      if (n_plot == 0) begin
        first_x = int'(x);
        first_y = int'(y);
      end
      n_plot++;
      if (colour == C_GREEN) n_green++;
      if (colour == C_BLACK) begin
        n_black++;
        if (int'(x) < blk_xmin) blk_xmin = int'(x);
        if (int'(x) > blk_xmax) blk_xmax = int'(x);
      end
      if (colour == C_RED) begin
        n_red++;
        if (int'(x) < red_xmin) red_xmin = int'(x);
        if (int'(x) > red_xmax) red_xmax = int'(x);
        if (int'(y) < red_ymin) red_ymin = int'(y);
        if (int'(y) > red_ymax) red_ymax = int'(y);
      end
      if (y == 7'd50) row_col[x] = colour;
    end
    if (frame_done === 1'b1) n_fd++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    clr_stats();

    // Reset values
    reset = 1'b1;
    run(3);
    check("rst_plot", 32'(plot), 0);
    check("rst_x", 32'(x), 0);
    check("rst_y", 32'(y), 0);
    check("rst_colour", 32'(colour), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_lane", 32'(lane), 1);

    // First frame: background then car in lane 1
    reset = 1'b0;
    clr_stats();
    run(19300);
    check("f1_plots", n_plot, 19260);
    check("f1_green", n_green, 7200);
    check("f1_black", n_black, 12000);
    check("f1_first_x", first_x, 0);
    check("f1_first_y", first_y, 0);
    check("f1_col_x29", 32'(row_col[29]), 32'(C_GREEN));
    check("f1_col_x30", 32'(row_col[30]), 32'(C_BLACK));
    check("f1_col_x129", 32'(row_col[129]), 32'(C_BLACK));
    check("f1_col_x130", 32'(row_col[130]), 32'(C_GREEN));
    check("f1_red", n_red, 60);
    check("f1_red_xmin", red_xmin, 77);
    check("f1_red_xmax", red_xmax, 81);
    check("f1_red_ymin", red_ymin, 104);
    check("f1_red_ymax", red_ymax, 115);
    check("f1_frame_done", n_fd, 1);
    check("f1_lane", 32'(lane), 1);
    check("f1_busy", 32'(busy), 0);

    // Start, then move left 1 -> 0
    clr_stats();
    start = 1'b1; tick(); start = 1'b0;
    move_left = 1'b1; tick(); move_left = 1'b0;
    run(200);
    check("ml_plots", n_plot, 120);
    check("ml_black", n_black, 60);
    check("ml_blk_xmin", blk_xmin, 77);
    check("ml_blk_xmax", blk_xmax, 81);
    check("ml_red", n_red, 60);
    check("ml_red_xmin", red_xmin, 44);
    check("ml_red_xmax", red_xmax, 48);
    check("ml_red_ymax", red_ymax, 115);
    check("ml_lane", 32'(lane), 0);
    check("ml_busy", 32'(busy), 0);
    check("ml_frame_done", n_fd, 0);

    // Left held in lane 0: clamped
    clr_stats();
    move_left = 1'b1; run(10); move_left = 1'b0; run(3);
    check("clampL_plots", n_plot, 0);
    check("clampL_lane", 32'(lane), 0);

    // Right pulse 0 -> 1
    clr_stats();
    move_right = 1'b1; tick(); move_right = 1'b0;
    run(200);
    check("mr1_lane", 32'(lane), 1);
    check("mr1_red_xmin", red_xmin, 77);
    check("mr1_blk_xmin", blk_xmin, 44);

    // Both together in lane 1: no move
    clr_stats();
    move_left = 1'b1; move_right = 1'b1; run(10);
    move_left = 1'b0; move_right = 1'b0; run(3);
    check("both_plots", n_plot, 0);
    check("both_lane", 32'(lane), 1);

    // Right pulse 1 -> 2
    clr_stats();
    move_right = 1'b1; tick(); move_right = 1'b0;
    run(200);
    check("mr2_lane", 32'(lane), 2);
    check("mr2_red_xmin", red_xmin, 110);
    check("mr2_red_xmax", red_xmax, 114);
    check("mr2_plots", n_plot, 120);

    // Right held in lane 2: clamped
    clr_stats();
    move_right = 1'b1; run(10); move_right = 1'b0; run(3);
    check("clampR_plots", n_plot, 0);
    check("clampR_lane", 32'(lane), 2);

    // Redraw from WAIT_MOVE: full repaint, car stays in lane 2
    clr_stats();
    redraw = 1'b1; tick(); redraw = 1'b0;
    run(19300);
    check("rd_plots", n_plot, 19260);
    check("rd_green", n_green, 7200);
    check("rd_red_xmin", red_xmin, 110);
    check("rd_frame_done", n_fd, 1);
    check("rd_lane", 32'(lane), 2);
    check("rd_busy", 32'(busy), 0);

    // Back in WAIT_START: moves are not sampled
    clr_stats();
    move_left = 1'b1; tick(); move_left = 1'b0;
    run(100);
    check("ws_plots", n_plot, 0);
    check("ws_lane", 32'(lane), 2);
    start = 1'b1; tick(); start = 1'b0;

    // Redraw during ERASE is dropped
    clr_stats();
    move_left = 1'b1; tick(); move_left = 1'b0;
    run(10);
    redraw = 1'b1; tick(); redraw = 1'b0;
    run(200);
    check("rde_plots", n_plot, 120);
    check("rde_green", n_green, 0);
    check("rde_frame_done", n_fd, 0);
    check("rde_lane", 32'(lane), 1);

    // Move to lane 0, then reset part-way through a repaint
    move_left = 1'b1; tick(); move_left = 1'b0;
    run(200);
    check("pre_rst_lane", 32'(lane), 0);
    clr_stats();
    redraw = 1'b1; tick(); redraw = 1'b0;
    for (int i = 0; i < 10000 && n_plot < 5000; i++) tick();
    check("mid_reach_5000", n_plot, 5000);
    reset = 1'b1; tick();
    check("mid_rst_plot", 32'(plot), 0);
    check("mid_rst_x", 32'(x), 0);
    check("mid_rst_y", 32'(y), 0);
    check("mid_rst_lane", 32'(lane), 1);
    check("mid_rst_busy", 32'(busy), 0);
    reset = 1'b0;
    clr_stats();
    run(19300);
    check("post_plots", n_plot, 19260);
    check("post_first_x", first_x, 0);
    check("post_first_y", first_y, 0);
    check("post_red_xmin", red_xmin, 77);
    check("post_frame_done", n_fd, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
